// File: rtl/mips_pkg.sv
// Shared MIPS-subset encodings for the ID stage: opcodes, functs, ALU op codes and the control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_OP_AND = 4'd0;
    localparam logic [3:0] ALU_OP_OR  = 4'd1;
    localparam logic [3:0] ALU_OP_ADD = 4'd2;
    localparam logic [3:0] ALU_OP_SUB = 4'd6;
    localparam logic [3:0] ALU_OP_SLT = 4'd7;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        DEST_NONE = 2'd0,
        DEST_RD   = 2'd1,
        DEST_RT   = 2'd2
    } dest_sel_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_decode_stage_if.sv
// Fetch/EX-facing bus of the ID stage; slave = the decode stage, master = its environment.
interface id_decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) ();
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [DATA_W-1:0] if_pc;
    logic              flush;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_dest;
    logic              if_stall;
    logic [REG_AW-1:0] readReg1;
    logic [REG_AW-1:0] readReg2;
    logic              id_valid;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_mem_to_reg;
    logic              id_alu_src;
    logic              id_branch;
    logic              id_jump;
    logic [3:0]        id_alu_op;
    logic [REG_AW-1:0] id_dest;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc;
    logic [25:0]       id_jtarget;
    logic              id_illegal;

    modport slave (
        input  if_valid, if_instr, if_pc, flush, ex_mem_read, ex_dest,
        output if_stall, readReg1, readReg2, id_valid, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, id_alu_src, id_branch, id_jump, id_alu_op,
               id_dest, id_rs, id_rt, id_imm, id_pc, id_jtarget, id_illegal
    );

    modport master (
        output if_valid, if_instr, if_pc, flush, ex_mem_read, ex_dest,
        input  if_stall, readReg1, readReg2, id_valid, id_reg_write, id_mem_read,
               id_mem_write, id_mem_to_reg, id_alu_src, id_branch, id_jump, id_alu_op,
               id_dest, id_rs, id_rt, id_imm, id_pc, id_jtarget, id_illegal
    );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/funct decoder: control bundle, destination select, illegal flag, rt-as-source.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_instr_zero,
    output ctrl_t      o_ctrl,
    output dest_sel_e  o_dest_sel,
    output logic       o_illegal,
    output logic       o_rt_is_src
);

    always_comb begin
        o_ctrl      = CTRL_NONE;
        o_dest_sel  = DEST_NONE;
        o_illegal   = 1'b0;
        o_rt_is_src = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                o_dest_sel  = DEST_RD;
                o_rt_is_src = 1'b1;
                case (i_funct)
                    FN_ADD: begin o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = ALU_OP_ADD; end
                    FN_SUB: begin o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = ALU_OP_SUB; end
                    FN_AND: begin o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = ALU_OP_AND; end
                    FN_OR:  begin o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = ALU_OP_OR;  end
                    FN_SLT: begin o_ctrl.reg_write = 1'b1; o_ctrl.alu_op = ALU_OP_SLT; end
                    // Only the all-zero word is a NOP; other shifts are outside the subset.
                    FN_NOP:  o_illegal = ~i_instr_zero;
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                o_dest_sel        = DEST_RT;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.alu_op     = ALU_OP_ADD;
            end
            OP_SW: begin
                o_rt_is_src      = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            OP_BEQ: begin
                o_rt_is_src   = 1'b1;
                o_ctrl.branch = 1'b1;
                o_ctrl.alu_op = ALU_OP_SUB;
            end
            OP_ADDI: begin
                o_dest_sel       = DEST_RT;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = ALU_OP_ADD;
            end
            OP_J:    o_ctrl.jump = 1'b1;
            default: o_illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_decode_stage.sv
// MIPS ID stage: register-file address wiring, load-use hazard stall, flush and the ID/EX register.
// Optional macro ID_ILLEGAL_TRAP_EN: sticky id_illegal flag, illegal ops issued as bubbles.
module id_decode_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input logic           clk,
    input logic           rst_n,
    id_decode_stage_if.slave bus
);

    logic [REG_AW-1:0] w_rs, w_rt, w_rd, w_dest;
    logic [DATA_W-1:0] w_imm;
    ctrl_t             w_ctrl_dec, w_ctrl;
    dest_sel_e         w_dest_sel;
    logic              w_illegal, w_rt_is_src, w_hazard, w_trap, w_issue;

    ctrl_t             r_ctrl;
    logic              r_valid;
    logic [REG_AW-1:0] r_dest, r_rs, r_rt;
    logic [DATA_W-1:0] r_imm, r_pc;
    logic [25:0]       r_jtarget;

    assign w_rs  = bus.if_instr[25:21];
    assign w_rt  = bus.if_instr[20:16];
    assign w_rd  = bus.if_instr[15:11];
    assign w_imm = {{(DATA_W-16){bus.if_instr[15]}}, bus.if_instr[15:0]};

    mips_ctrl_decode u_dec (
        .i_op         (bus.if_instr[31:26]),
        .i_funct      (bus.if_instr[5:0]),
        .i_instr_zero (bus.if_instr == '0),
        .o_ctrl       (w_ctrl_dec),
        .o_dest_sel   (w_dest_sel),
        .o_illegal    (w_illegal),
        .o_rt_is_src  (w_rt_is_src)
    );

    always_comb begin
        case (w_dest_sel)
            DEST_RD: w_dest = w_rd;
            DEST_RT: w_dest = w_rt;
            default: w_dest = '0;
        endcase
        w_ctrl           = w_ctrl_dec;
        w_ctrl.reg_write = w_ctrl_dec.reg_write & (w_dest != REG_ZERO);
    end

    assign w_hazard = bus.if_valid & bus.ex_mem_read & (bus.ex_dest != REG_ZERO) &
                      ((bus.ex_dest == w_rs) | ((bus.ex_dest == w_rt) & w_rt_is_src));

`ifdef ID_ILLEGAL_TRAP_EN
    assign w_trap = w_illegal;
`else
    assign w_trap = 1'b0;
`endif

    assign w_issue = bus.if_valid & ~bus.flush & ~w_hazard & ~w_trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_ctrl    <= CTRL_NONE;
            r_dest    <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
            r_jtarget <= '0;
        end else begin
            // Data fields track the fetched word every cycle; only control/valid are gated.
            r_valid   <= w_issue;
            r_ctrl    <= w_issue ? w_ctrl : CTRL_NONE;
            r_dest    <= w_dest;
            r_rs      <= w_rs;
            r_rt      <= w_rt;
            r_imm     <= w_imm;
            r_pc      <= bus.if_pc;
            r_jtarget <= bus.if_instr[25:0];
        end
    end

`ifdef ID_ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_illegal <= 1'b0;
        else if (bus.if_valid & ~bus.flush & ~w_hazard & w_illegal)
            r_illegal <= 1'b1;
    end
    assign bus.id_illegal = r_illegal;
`else
    assign bus.id_illegal = 1'b0;
`endif

    assign bus.readReg1      = w_rs;
    assign bus.readReg2      = w_rt;
    assign bus.if_stall      = rst_n & w_hazard & ~bus.flush;
    assign bus.id_valid      = r_valid;
    assign bus.id_reg_write  = r_ctrl.reg_write;
    assign bus.id_mem_read   = r_ctrl.mem_read;
    assign bus.id_mem_write  = r_ctrl.mem_write;
    assign bus.id_mem_to_reg = r_ctrl.mem_to_reg;
    assign bus.id_alu_src    = r_ctrl.alu_src;
    assign bus.id_branch     = r_ctrl.branch;
    assign bus.id_jump       = r_ctrl.jump;
    assign bus.id_alu_op     = r_ctrl.alu_op;
    assign bus.id_dest       = r_dest;
    assign bus.id_rs         = r_rs;
    assign bus.id_rt         = r_rt;
    assign bus.id_imm        = r_imm;
    assign bus.id_pc         = r_pc;
    assign bus.id_jtarget    = r_jtarget;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode, load-use stall, flush priority, reset and illegal ops.
module tb_id_decode_stage;

    logic clk;
    logic rst_n;
    int unsigned checks;
    int unsigned errors;

    id_decode_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_decode_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump}
    function automatic logic [6:0] ctl();
        return {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_mem_to_reg,
                bus.id_alu_src, bus.id_branch, bus.id_jump};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic fl, input logic exr, input logic [4:0] exd);
        bus.if_valid    = v;
        bus.if_instr    = instr;
        bus.if_pc       = pc;
        bus.flush       = fl;
        bus.ex_mem_read = exr;
        bus.ex_dest     = exd;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        tick();
        tick();
        check("reset_valid", {63'd0, bus.id_valid}, 64'd0);
        check("reset_ctl",   {57'd0, ctl()},        64'd0);
        check("reset_stall", {63'd0, bus.if_stall}, 64'd0);
        check("reset_illegal", {63'd0, bus.id_illegal}, 64'd0);
        rst_n = 1'b1;

        // add $3,$1,$2
        drive(1'b1, 32'h00221820, 32'h00000104, 1'b0, 1'b0, 5'd0);
        check("add_readReg1", {59'd0, bus.readReg1}, 64'd1);
        check("add_readReg2", {59'd0, bus.readReg2}, 64'd2);
        check("add_nostall",  {63'd0, bus.if_stall}, 64'd0);
        tick();
        check("add_valid", {63'd0, bus.id_valid},  64'd1);
        check("add_ctl",   {57'd0, ctl()},         64'b1000000);
        check("add_dest",  {59'd0, bus.id_dest},   64'd3);
        check("add_aluop", {60'd0, bus.id_alu_op}, 64'd2);
        check("add_rs_rt", {54'd0, bus.id_rs, bus.id_rt}, {54'd0, 5'd1, 5'd2});
        check("add_pc",    {32'd0, bus.id_pc},     64'h104);
        check("add_imm",   {32'd0, bus.id_imm},    64'h1820);

        // sub $6,$5,$7 behind lw $5: stall one cycle, then issue
        drive(1'b1, 32'h00A73022, 32'h00000108, 1'b0, 1'b1, 5'd5);
        check("rs_hazard_stall", {63'd0, bus.if_stall}, 64'd1);
        tick();
        check("stall_bubble_valid", {63'd0, bus.id_valid}, 64'd0);
        check("stall_bubble_ctl",   {57'd0, ctl()},        64'd0);
        drive(1'b1, 32'h00A73022, 32'h00000108, 1'b0, 1'b0, 5'd0);
        check("stall_release", {63'd0, bus.if_stall}, 64'd0);
        tick();
        check("sub_valid", {63'd0, bus.id_valid},  64'd1);
        check("sub_ctl",   {57'd0, ctl()},         64'b1000000);
        check("sub_dest",  {59'd0, bus.id_dest},   64'd6);
        check("sub_aluop", {60'd0, bus.id_alu_op}, 64'd6);

        // rt as a source (R-type, sw) stalls
        drive(1'b1, 32'h00A73022, 32'h0000010C, 1'b0, 1'b1, 5'd7);
        check("rt_hazard_rtype", {63'd0, bus.if_stall}, 64'd1);
        drive(1'b1, 32'hAC450000, 32'h0000010C, 1'b0, 1'b1, 5'd5);
        check("rt_hazard_sw", {63'd0, bus.if_stall}, 64'd1);
        // EX not a load: no stall
        drive(1'b1, 32'hAC450000, 32'h0000010C, 1'b0, 1'b0, 5'd5);
        check("no_load_no_stall", {63'd0, bus.if_stall}, 64'd0);
        tick();
        check("sw_ctl",  {57'd0, ctl()},       64'b0010100);
        check("sw_dest", {59'd0, bus.id_dest}, 64'd0);

        // addi $5,$0,-1: rt is a destination only
        drive(1'b1, 32'h2005FFFF, 32'h00000110, 1'b0, 1'b1, 5'd5);
        check("addi_no_stall", {63'd0, bus.if_stall}, 64'd0);
        drive(1'b1, 32'h2005FFFF, 32'h00000110, 1'b0, 1'b1, 5'd0);
        check("exdest0_no_stall", {63'd0, bus.if_stall}, 64'd0);
        tick();
        check("addi_valid", {63'd0, bus.id_valid}, 64'd1);
        check("addi_ctl",   {57'd0, ctl()},        64'b1000100);
        check("addi_dest",  {59'd0, bus.id_dest},  64'd5);
        check("addi_imm",   {32'd0, bus.id_imm},   64'hFFFFFFFF);

        // flush beats hazard
        drive(1'b1, 32'h00A73022, 32'h00000114, 1'b1, 1'b1, 5'd5);
        check("flush_no_stall", {63'd0, bus.if_stall}, 64'd0);
        tick();
        check("flush_valid", {63'd0, bus.id_valid}, 64'd0);
        check("flush_ctl",   {57'd0, ctl()},        64'd0);

        // lw $8,4($9)
        drive(1'b1, 32'h8D280004, 32'h00000118, 1'b0, 1'b0, 5'd0);
        tick();
        check("lw_ctl",   {57'd0, ctl()},       64'b1101100);
        check("lw_dest",  {59'd0, bus.id_dest}, 64'd8);

        // beq $1,$2,-2
        drive(1'b1, 32'h1022FFFE, 32'h0000011C, 1'b0, 1'b0, 5'd0);
        tick();
        check("beq_ctl",   {57'd0, ctl()},         64'b0000010);
        check("beq_aluop", {60'd0, bus.id_alu_op}, 64'd6);
        check("beq_imm",   {32'd0, bus.id_imm},    64'hFFFFFFFE);

        // j 0x40
        drive(1'b1, 32'h08000040, 32'h00000120, 1'b0, 1'b0, 5'd0);
        tick();
        check("j_ctl",     {57'd0, ctl()},          64'b0000001);
        check("j_target",  {38'd0, bus.id_jtarget}, 64'h40);

        // add $0,$1,$2: write to $0 suppressed
        drive(1'b1, 32'h00220020, 32'h00000124, 1'b0, 1'b0, 5'd0);
        tick();
        check("r0_valid", {63'd0, bus.id_valid}, 64'd1);
        check("r0_ctl",   {57'd0, ctl()},        64'd0);

        // if_valid=0 loads a bubble, pc still follows
        drive(1'b0, 32'h00221820, 32'h00000128, 1'b0, 1'b0, 5'd0);
        tick();
        check("invalid_valid", {63'd0, bus.id_valid}, 64'd0);
        check("invalid_ctl",   {57'd0, ctl()},        64'd0);
        check("invalid_pc",    {32'd0, bus.id_pc},    64'h128);

        // NOP
        drive(1'b1, 32'h00000000, 32'h0000012C, 1'b0, 1'b0, 5'd0);
        tick();
        check("nop_valid", {63'd0, bus.id_valid}, 64'd1);
        check("nop_ctl",   {57'd0, ctl()},        64'd0);

        // illegal op 0x3F
        drive(1'b1, 32'hFC000000, 32'h00000130, 1'b0, 1'b0, 5'd0);
        tick();
`ifdef ID_ILLEGAL_TRAP_EN
        check("illegal_valid", {63'd0, bus.id_valid},   64'd0);
        check("illegal_flag",  {63'd0, bus.id_illegal}, 64'd1);
`else
        check("illegal_valid", {63'd0, bus.id_valid},   64'd1);
        check("illegal_flag",  {63'd0, bus.id_illegal}, 64'd0);
`endif
        check("illegal_ctl", {57'd0, ctl()}, 64'd0);
        drive(1'b1, 32'h00221820, 32'h00000134, 1'b0, 1'b0, 5'd0);
        tick();
        check("after_illegal_valid", {63'd0, bus.id_valid}, 64'd1);
`ifdef ID_ILLEGAL_TRAP_EN
        check("illegal_sticky", {63'd0, bus.id_illegal}, 64'd1);
`else
        check("illegal_tied0",  {63'd0, bus.id_illegal}, 64'd0);
`endif

        // reset asserted mid-stall, away from any clock edge
        drive(1'b1, 32'h00A73022, 32'h00000138, 1'b0, 1'b1, 5'd5);
        check("pre_reset_stall", {63'd0, bus.if_stall}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", {63'd0, bus.id_valid}, 64'd0);
        check("async_reset_ctl",   {57'd0, ctl()},        64'd0);
        check("async_reset_pc",    {32'd0, bus.id_pc},    64'd0);
        check("async_reset_dest",  {59'd0, bus.id_dest},  64'd0);
        check("async_reset_stall", {63'd0, bus.if_stall}, 64'd0);
        check("async_reset_illegal", {63'd0, bus.id_illegal}, 64'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
